// File: rtl/seven_segment_reader.sv
// seven_segment_reader
//   Receive end of the multiplexed 7-segment PMOD display interface. Samples
//   the raw bus, waits for each digit to settle, decodes the segment pattern
//   back to a nibble and pairs a high and a low digit into one byte. Each
//   byte is offered on a valid/ready handshake.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pmod_in[7:0] raw bus: [6:0] segments A-G active-low, [7] digit select
//                (0 = high nibble, 1 = low nibble); asynchronous to clk
//   ready        consumer takes value when valid && ready
//   value[7:0]   reassembled byte {high nibble, low nibble}
//   valid        value holds an undelivered byte
//   pattern_err  one-cycle pulse: an accepted digit had an illegal pattern
//   overrun      one-cycle pulse: a completed byte was dropped (output busy)
//
// Parameter
//   STABLE_CYCLES  identical synchronized samples needed to accept a digit,
//                  legal range 1..15
//
// Build option
//   SEVEN_SEGMENT_READER_DEDUP_EN  when defined, a completed byte equal to
//   the last byte loaded into value is discarded silently.

module seven_segment_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pmod_in,
  input  logic       ready,
  output logic [7:0] value,
  output logic       valid,
  output logic       pattern_err,
  output logic       overrun
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

  typedef enum logic {
    WAIT_HI,
    WAIT_LO
  } state_t;

  // Synchronizer and sample-qualification flags. The flags mark which sync
  // stages hold a real bus sample, so the first sample after reset always
  // starts a fresh run even if it equals the reset value of sync2.
  logic [7:0] sync1_q, sync2_q;
  logic       s1_vld_q, s2_vld_q;

  // Run counter; fresh_q is set when the count moved on the last edge, so a
  // count parked at STABLE_CNT (saturation) cannot re-trigger an accept.
  logic [3:0] cnt_q, cnt_d;
  logic       fresh_q, fresh_d;
  logic       accept;

  logic [3:0] nib;
  logic       legal;
  logic       sel;

  state_t     state_q, state_d;
  logic [3:0] hi_q, hi_d;
  logic       byte_done;
  logic [7:0] byte_val;
  logic       err_d;

  logic [7:0] value_q, value_d;
  logic       valid_q, valid_d;
  logic       err_q;
  logic       ovr_q, ovr_d;
  logic       load;
  logic       dup;

  // ---------------------------------------------------------------------
  // Run counter next state
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    cnt_d   = cnt_q;
    fresh_d = 1'b0;
    if (s1_vld_q) begin
      if (!s2_vld_q || (sync1_q != sync2_q)) begin
        cnt_d   = 4'd1;
        fresh_d = 1'b1;
      end else if (cnt_q != 4'hF) begin
        cnt_d   = cnt_q + 4'd1;
        fresh_d = 1'b1;
      end
    end
  end

  assign accept = fresh_q && (cnt_q == STABLE_CNT);
  assign sel    = sync2_q[7];

  // ---------------------------------------------------------------------
  // Segment decode: exact inverse of the display driver's table
  // ---------------------------------------------------------------------
  always_comb begin
    nib   = 4'h0;
    legal = 1'b1;
    case (sync2_q[6:0])
      7'h40:   nib = 4'h0;
      7'h79:   nib = 4'h1;
      7'h24:   nib = 4'h2;
      7'h30:   nib = 4'h3;
      7'h19:   nib = 4'h4;
      7'h12:   nib = 4'h5;
      7'h02:   nib = 4'h6;
      7'h78:   nib = 4'h7;
      7'h00:   nib = 4'h8;
      7'h10:   nib = 4'h9;
      7'h08:   nib = 4'hA;
      7'h03:   nib = 4'hB;
      7'h46:   nib = 4'hC;
      7'h21:   nib = 4'hD;
      7'h06:   nib = 4'hE;
      7'h0E:   nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Digit-pairing FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    byte_done = 1'b0;
    byte_val  = {hi_q, nib};
    err_d     = 1'b0;
    if (accept) begin
      if (!legal) begin
        err_d   = 1'b1;
        state_d = WAIT_HI;
      end else begin
        case (state_q)
          WAIT_HI: begin
            if (!sel) begin
              hi_d    = nib;
              state_d = WAIT_LO;
            end
          end
          WAIT_LO: begin
            if (!sel) begin
              hi_d = nib;
            end else begin
              byte_done = 1'b1;
              state_d   = WAIT_HI;
            end
          end
          default: state_d = WAIT_HI;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output stage: a delivery in the same cycle frees the slot for a new byte
  // ---------------------------------------------------------------------
  always_comb begin
    value_d = value_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    load    = 1'b0;
    if (valid_q && ready) valid_d = 1'b0;
    if (byte_done && !dup) begin
      if (!valid_q || ready) begin
        load    = 1'b1;
        value_d = byte_val;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

`ifdef SEVEN_SEGMENT_READER_DEDUP_EN
  // value_q keeps its contents after delivery, so it always holds the last
  // loaded byte; loaded_q tells whether any byte has been loaded yet.
  logic loaded_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    loaded_q <= 1'b0;
    else if (load) loaded_q <= 1'b1;
  end

  assign dup = loaded_q && (byte_val == value_q);
`else
  assign dup = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 8'h00;
      sync2_q  <= 8'h00;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      cnt_q    <= 4'h0;
      fresh_q  <= 1'b0;
      state_q  <= WAIT_HI;
      hi_q     <= 4'h0;
      value_q  <= 8'h00;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      sync1_q  <= pmod_in;
      sync2_q  <= sync1_q;
      s1_vld_q <= 1'b1;
      s2_vld_q <= s1_vld_q;
      cnt_q    <= cnt_d;
      fresh_q  <= fresh_d;
      state_q  <= state_d;
      hi_q     <= hi_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  assign value       = value_q;
  assign valid       = valid_q;
  assign pattern_err = err_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader
//   Self-checking bench for seven_segment_reader. Directed scenarios cover the
//   cycle timing and corner cases; a randomized digit stream is checked
//   against a digit-level reference model (decode by table lookup, pairing
//   and dedup rules applied per held digit).

module tb_seven_segment_reader;

  localparam int STABLE = 4;

  // Active-high segment images (gfedcba) of hex digits 0..F as drawn by the
  // display driver; the bus carries their complement.
  localparam logic [6:0] SEG_ON [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pmod_in;
  logic       ready;
  logic [7:0] value;
  logic       valid;
  logic       pattern_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q [$];
  int         err_cycles = 0;
  int         ovr_cycles = 0;

  seven_segment_reader #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pmod_in     (pmod_in),
    .ready       (ready),
    .value       (value),
    .valid       (valid),
    .pattern_err (pattern_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Monitor: record delivered bytes and pulse cycles on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) got_q.push_back(value);
      if (pattern_err) err_cycles++;
      if (overrun) ovr_cycles++;
    end
  end

  function automatic logic [6:0] seg_of(input int n);
    return ~SEG_ON[n];
  endfunction

  function automatic int nib_of(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (~SEG_ON[i] == p) return i;
    return -1;
  endfunction

  // Called at posedge+1; leaves time at posedge+1.
  task automatic do_reset();
    rst_n   = 1'b0;
    pmod_in = 8'hFF;
    ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    pmod_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (value !== 8'h00) begin errors++; $display("FAIL %s value got %h want 00", tag, value); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL %s valid got %b want 0", tag, valid); end
    checks++;
    if (pattern_err !== 1'b0) begin errors++; $display("FAIL %s pattern_err got %b want 0", tag, pattern_err); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL %s overrun got %b want 0", tag, overrun); end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    pmod_in = 8'h30;
    ready   = 1'b1;
    #1 check_idle_outputs("reset");
    @(posedge clk);
    #1 do_reset();
  endtask

  task automatic test_single_frame();
    do_reset();
    hold(8'h30, 16);
    pmod_in = 8'h92;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (valid !== (i == STABLE + 2)) begin
        errors++;
        $display("FAIL single_frame valid at edge %0d got %b want %b", i, valid, (i == STABLE + 2));
      end
      if (i == STABLE + 2) begin
        checks++;
        if (value !== 8'h35) begin errors++; $display("FAIL single_frame value got %h want 35", value); end
      end
    end
  endtask

  task automatic test_glitch();
    int base, e0;
    do_reset();
    base = got_q.size();
    e0   = err_cycles;
    hold(8'h30, 10);
    hold(8'h31, 2);
    hold(8'h30, 16);
    hold(8'h92, 16);
    checks++;
    if (err_cycles - e0 !== 0) begin errors++; $display("FAIL glitch pattern_err cycles got %0d want 0", err_cycles - e0); end
    checks++;
    if (got_q.size() - base !== 1) begin
      errors++; $display("FAIL glitch byte count got %0d want 1", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] !== 8'h35) begin errors++; $display("FAIL glitch byte got %h want 35", got_q[base]); end
    end
  endtask

  task automatic test_illegal();
    int base, e0;
    do_reset();
    base = got_q.size();
    e0   = err_cycles;
    hold(8'h7F, 16);
    hold(8'h92, 16);
    checks++;
    if (err_cycles - e0 !== 1) begin errors++; $display("FAIL illegal pattern_err cycles got %0d want 1", err_cycles - e0); end
    checks++;
    if (got_q.size() - base !== 0) begin errors++; $display("FAIL illegal byte count got %0d want 0", got_q.size() - base); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL illegal valid got %b want 0", valid); end
  endtask

  task automatic test_backpressure();
    int base, o0;
    do_reset();
    ready = 1'b0;
    base  = got_q.size();
    o0    = ovr_cycles;
    hold(8'h30, 16);
    hold(8'h92, 16);
    hold(8'h40, 16);
    hold(8'h80, 16);
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL backpressure valid got %b want 1", valid); end
    checks++;
    if (value !== 8'h35) begin errors++; $display("FAIL backpressure value got %h want 35", value); end
    checks++;
    if (ovr_cycles - o0 !== 1) begin errors++; $display("FAIL backpressure overrun cycles got %0d want 1", ovr_cycles - o0); end
    ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL backpressure valid after ready got %b want 0", valid); end
    checks++;
    if (value !== 8'h35) begin errors++; $display("FAIL backpressure value after ready got %h want 35", value); end
    checks++;
    if (got_q.size() - base !== 1) begin errors++; $display("FAIL backpressure deliveries got %0d want 1", got_q.size() - base); end
  endtask

  task automatic test_reset_mid_frame();
    int base, e0;
    do_reset();
    ready = 1'b0;
    hold(8'h30, 16);
    hold(8'h92, 16);
    hold(8'h30, 16);
    pmod_in = 8'h92;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("mid_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ready = 1'b1;
    base  = got_q.size();
    e0    = err_cycles;
    hold(8'h92, 16);
    checks++;
    if (got_q.size() - base !== 0) begin errors++; $display("FAIL mid_reset stray byte count got %0d want 0", got_q.size() - base); end
    checks++;
    if (err_cycles - e0 !== 0) begin errors++; $display("FAIL mid_reset pattern_err cycles got %0d want 0", err_cycles - e0); end
    hold(8'h30, 16);
    hold(8'h92, 16);
    checks++;
    if (got_q.size() - base !== 1) begin
      errors++; $display("FAIL mid_reset fresh byte count got %0d want 1", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] !== 8'h35) begin errors++; $display("FAIL mid_reset fresh byte got %h want 35", got_q[base]); end
    end
  endtask

  task automatic test_dedup();
    int base, want;
`ifdef SEVEN_SEGMENT_READER_DEDUP_EN
    want = 1;
`else
    want = 3;
`endif
    do_reset();
    base = got_q.size();
    for (int k = 0; k < 3; k++) begin
      hold(8'h30, 16);
      hold(8'h92, 16);
    end
    checks++;
    if (got_q.size() - base !== want) begin
      errors++; $display("FAIL dedup byte count got %0d want %0d", got_q.size() - base, want);
    end
    for (int k = base; k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== 8'h35) begin errors++; $display("FAIL dedup byte %0d got %h want 35", k - base, got_q[k]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q [$];
    logic [7:0] prev, v, b, last;
    logic [6:0] p;
    logic       have_hi, has_last;
    logic [3:0] hi;
    int         base, e0, o0, exp_err, n;
    do_reset();
    base     = got_q.size();
    e0       = err_cycles;
    o0       = ovr_cycles;
    exp_err  = 0;
    have_hi  = 1'b0;
    hi       = 4'h0;
    has_last = 1'b0;
    last     = 8'h00;
    prev     = pmod_in;
    for (int k = 0; k < 60; k++) begin
      do begin
        if ($urandom_range(0, 7) == 0) begin
          do p = 7'($urandom_range(0, 127)); while (nib_of(p) >= 0);
        end else begin
          p = seg_of(int'($urandom_range(0, 15)));
        end
        v = {1'($urandom_range(0, 1)), p};
      end while (v == prev);
      prev = v;
      hold(v, int'($urandom_range(STABLE + 2, 20)));
      n = nib_of(v[6:0]);
      if (n < 0) begin
        exp_err++;
        have_hi = 1'b0;
      end else if (!v[7]) begin
        have_hi = 1'b1;
        hi      = 4'(n);
      end else if (have_hi) begin
        have_hi = 1'b0;
        b       = {hi, 4'(n)};
`ifdef SEVEN_SEGMENT_READER_DEDUP_EN
        if (!(has_last && b == last)) exp_q.push_back(b);
`else
        exp_q.push_back(b);
`endif
        has_last = 1'b1;
        last     = b;
      end
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (err_cycles - e0 !== exp_err) begin
      errors++; $display("FAIL random pattern_err cycles got %0d want %0d", err_cycles - e0, exp_err);
    end
    checks++;
    if (ovr_cycles - o0 !== 0) begin errors++; $display("FAIL random overrun cycles got %0d want 0", ovr_cycles - o0); end
    checks++;
    if (got_q.size() - base !== exp_q.size()) begin
      errors++; $display("FAIL random byte count got %0d want %0d", got_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (got_q[base + k] !== exp_q[k]) begin
          errors++; $display("FAIL random byte %0d got %h want %h", k, got_q[base + k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_illegal();
    test_backpressure();
    test_reset_mid_frame();
    test_dedup();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Recovers a 2-digit hex value from a multiplexed 7-segment PMOD bus: segments A–G active-low on bits 0–6 (0 = lit), digit select on bit 7 (0 = high nibble, 1 = low nibble). It is the receive end of our display interface. Uses include loopback self-test of the display driver and reading another design's display output. Each reassembled byte is presented on a valid/ready handshake, and illegal segment patterns are flagged.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronized samples required to accept a digit; legal range 1..15.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- pmod_in  in  8  raw PMOD bus, asynchronous to clk.
- ready  in  1  consumer accepts `value` when `valid && ready`.
- value  out  8  reassembled byte, {high nibble, low nibble}.
- valid  out  1  `value` holds an undelivered byte.
- pattern_err  out  1  one-cycle pulse: an accepted sample had an illegal segment pattern.
- overrun  out  1  one-cycle pulse: a completed byte was dropped because the output was occupied.

## Operation
- **Synchronizer:** all 8 bits pass through a 2-flop synchronizer (sync1 → sync2).
- **Run counter (4-bit, saturating):**
  - Loads 1 when sync2 takes a value different from its previous value; otherwise increments.
  - The accept strobe fires only on the cycle the count first equals STABLE_CYCLES, so there is exactly one accept per stable run.
- **Decode:** 7-bit pattern to nibble, exactly inverting the driver's table (e.g. 7'h40 → 0, 7'h00 → 8, 7'h12 → 5, 7'h30 → 3). Any of the other 112 patterns, including blank 7'h7F, is illegal.
- **FSM states:** WAIT_HI (reset state) and WAIT_LO. On each accept:
  - Illegal pattern, any state: pulse pattern_err; go to WAIT_HI.
  - WAIT_HI, sel=0: latch hi nibble; go to WAIT_LO.
  - WAIT_HI, sel=1: ignored.
  - WAIT_LO, sel=0: re-latch hi nibble; stay in WAIT_LO.
  - WAIT_LO, sel=1: byte complete = {hi, nibble}; go to WAIT_HI.
- **Output stage (on byte complete):**
  - `!valid`, or `valid && ready` in the same cycle: load value and set valid=1.
  - `valid && !ready`: drop the byte, keep the old value, pulse overrun.
- **Delivery:** `valid && ready` with no byte completing clears valid; value keeps its last contents.
- **Reset:** rst_n low at any time, including mid-frame, clears everything immediately. The synchronizer and counter go to 0, the FSM to WAIT_HI, and value, valid, pattern_err and overrun to 0. The first sample after reset counts as a change.

## Timing
- Edge 1 is the first clk edge that samples a new pmod_in value.
- On a byte-completing low digit, value and valid update on edge STABLE_CYCLES+2 (edge 6 at the default).
- pattern_err and overrun are registered and high for exactly one cycle, on the same edge a valid update would have occurred.
- Handshake: valid stays asserted until sampled with ready=1; value is stable while valid=1. ready is ignored while valid=0.
- Source digit periods must be at least STABLE_CYCLES+2 clk cycles. The display driver's 16-cycle period works for STABLE_CYCLES ≤ 14.
- Throughput: at most one byte per two accepted digits.

## Configuration
- SEVEN_SEGMENT_READER_DEDUP_EN
  - Defined: a completed byte equal to the last byte loaded into `value` since reset is discarded silently: no valid, no overrun. The first byte after reset is always presented.
  - Undefined: every completed byte is presented.

## Test plan
- **Single frame.** Stimulus: after reset, drive 8'h30 for 16 cycles, then 8'h92 for 16 cycles, ready=1. Required: value=8'h35 with valid high for one cycle, on edge 6 of the 8'h92 period.
- **Glitch rejection.** Stimulus: in the middle of a steady 8'h30, drive 8'h31 for 2 cycles. Required: no accept of 8'h31, no pattern_err; byte completes normally afterwards.
- **Illegal pattern.** Stimulus: drive 8'h7F (sel=0, blank) for 16 cycles, then 8'h92. Required: one pattern_err pulse, no valid (FSM in WAIT_HI ignores the sel=1 digit).
- **Backpressure.** Stimulus: hold ready=0 across two frames, 0x35 then 8'h40/8'h80 (0x08). Required: value stays 8'h35 with valid high, one overrun pulse; raising ready clears valid after one cycle.
- **Reset mid-frame.** Stimulus: assert rst_n=0 in WAIT_LO after hi=3 is latched, release, then drive 8'h92. Required: all outputs 0 during reset; no valid after release until a fresh high digit arrives.
- **Dedup.** Stimulus: send 0x35 three times with ready=1. Required with SEVEN_SEGMENT_READER_DEDUP_EN: one valid pulse. Required without it: three valid pulses.
